// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and the 64-bit arithmetic helpers.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // 32x32 -> 64 product, {HI, LO} ordering.
  function automatic logic [63:0] mdu_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] p;
    if (is_signed) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return p;
  endfunction

  // Quotient truncated toward zero, remainder carries the dividend's sign.
  // Returned as {remainder, quotient} so it lines up with {HI, LO}.
  // The only signed overflow case is pinned explicitly rather than left to
  // the simulator's native division.
  function automatic logic [63:0] mdu_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
    logic [31:0] q;
    logic [31:0] r;
    q = '0;
    r = '0;
    if (b != '0) begin
      if (is_signed) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = '0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EXE-stage multiply/divide unit. Owns HI/LO, runs MULT/MULTU/DIV/DIVU as
// fixed-latency operations signalled by Busy, and services MTHI/MTLO writes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic        WE,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e        state;
  mdu_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       tmp_hi;
  logic [31:0]       tmp_lo;
  logic              commit_en;
  logic [63:0]       md_result;
  logic              start_ok;
  logic              mt_ok;
  logic              last_cycle;
  logic              is_div;

  assign is_div     = Op[1];
  assign start_ok   = Start && !Op[2] && (state == ST_IDLE);
  // A Start on the same edge suppresses any MT write.
  assign mt_ok      = WE && !Start && (state == ST_IDLE) &&
                      (Op == MDU_MTHI || Op == MDU_MTLO);
  assign last_cycle = (state == ST_RUN) && (cnt == CNT_W'(1));

  // Busy is a pure decode of the registered state.
  always_comb Busy = (state == ST_RUN);

  // Full 64-bit result for the op being issued; even op codes are signed.
  always_comb begin
    md_result = '0;
    if (is_div) md_result = mdu_div(D1, D2, !Op[0]);
    else        md_result = mdu_mul(D1, D2, !Op[0]);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: issue from IDLE, return when the counter expires.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok)   state_nxt = ST_RUN;
      ST_RUN:  if (last_cycle) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latency counter and result staging; divide-by-zero runs full length without commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      tmp_hi    <= '0;
      tmp_lo    <= '0;
      commit_en <= 1'b0;
    end else if (start_ok) begin
      cnt       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      tmp_hi    <= md_result[63:32];
      tmp_lo    <= md_result[31:0];
      commit_en <= !(is_div && D2 == '0);
    end else if (state == ST_RUN) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Architectural HI/LO: commit on the final RUN edge, or direct MT writes in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (last_cycle) begin
      if (commit_en) begin
        HI <= tmp_hi;
        LO <= tmp_lo;
      end
    end else if (mt_ok) begin
      if (Op == MDU_MTHI) HI <= D1;
      else                LO <= D1;
    end
  end

endmodule
